// File: rtl/mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage access controller. It sits on the consumer side of the EX/MEM
// pipeline register, issues one request per instruction to a multi-cycle data
// memory, and freezes the EX/MEM register (enable = ~stall) until the access
// completes. Misaligned accesses and memory timeouts put the block into a
// terminal error state that only rst clears.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in BUSY before a timeout (1..255)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   EXMEM_memRead/memWrite/noOp    access request fields from EX/MEM
//   EXMEM_memAddr, EXMEM_writeData byte address and store data
//   mem_Stall, mem_Done            memory handshake inputs
//   mem_DataOut                    memory read data
//   mem_Rd, mem_Wr                 request strobes to memory
//   mem_Addr, mem_DataIn           address / write data to memory
//   readData                       load result toward MEM/WB
//   stall                          freeze EX/MEM and upstream stages
//   err                            sticky error flag
//
// Optional build macro MEM_STAGE_STATS_EN adds acc_count / stall_count ports.
// ----------------------------------------------------------------------------
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EXMEM_memRead,
   input  logic        EXMEM_memWrite,
   input  logic        EXMEM_noOp,
   input  logic [15:0] EXMEM_memAddr,
   input  logic [15:0] EXMEM_writeData,
   input  logic        mem_Stall,
   input  logic        mem_Done,
   input  logic [15:0] mem_DataOut,
   output logic        mem_Rd,
   output logic        mem_Wr,
   output logic [15:0] mem_Addr,
   output logic [15:0] mem_DataIn,
   output logic [15:0] readData,
`ifdef MEM_STAGE_STATS_EN
   output logic [15:0] acc_count,
   output logic [15:0] stall_count,
`endif
   output logic        stall,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   // 9 bits so the comparison never overflows even at TIMEOUT_CYCLES = 255
   localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT_CYCLES);

   state_t      state_reg, state_next;
   logic [7:0]  wait_cnt_reg, wait_cnt_next;
   logic [15:0] rdata_reg;
   logic        is_read_reg, is_read_next;

   logic req, misalign, rd_sel, wr_sel;
   logic accept, capture;

   assign req      = (EXMEM_memRead | EXMEM_memWrite) & ~EXMEM_noOp;
   assign misalign = req & EXMEM_memAddr[0];
   // read wins when both strobes are set
   assign rd_sel   = EXMEM_memRead;
   assign wr_sel   = EXMEM_memWrite & ~EXMEM_memRead;

   assign mem_Addr   = EXMEM_memAddr;
   assign mem_DataIn = EXMEM_writeData;

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      is_read_next  = is_read_reg;
      mem_Rd        = 1'b0;
      mem_Wr        = 1'b0;
      stall         = 1'b0;
      accept        = 1'b0;
      capture       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (misalign) begin
               stall      = 1'b1;
               state_next = ERR;
            end else if (req) begin
               mem_Rd = rd_sel;
               mem_Wr = wr_sel;
               if (mem_Stall) begin
                  // memory not ready: hold the request and the pipeline
                  stall = 1'b1;
               end else begin
                  accept = 1'b1;
                  if (mem_Done) begin
                     // single-cycle hit, no extra latency
                     capture = rd_sel;
                  end else begin
                     stall         = 1'b1;
                     state_next    = BUSY;
                     wait_cnt_next = 8'd0;
                     is_read_next  = rd_sel;
                  end
               end
            end
         end
         BUSY: begin
            if (mem_Done) begin
               // stall drops here so EX/MEM advances and no re-issue occurs
               capture    = is_read_reg;
               state_next = IDLE;
            end else begin
               stall         = 1'b1;
               wait_cnt_next = wait_cnt_reg + 8'd1;
               if ({1'b0, wait_cnt_reg} + 9'd1 >= TIMEOUT_W)
                  state_next = ERR;
            end
         end
         ERR: begin
            stall = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 8'd0;
         rdata_reg    <= 16'h0000;
         is_read_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         is_read_reg  <= is_read_next;
         if (capture)
            rdata_reg <= mem_DataOut;
      end
   end

   // read data is forwarded in the completion cycle, then held
   assign readData = capture ? mem_DataOut : rdata_reg;
   assign err      = (state_reg == ERR);

`ifdef MEM_STAGE_STATS_EN
   logic [15:0] acc_count_reg, stall_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_count_reg   <= 16'h0000;
         stall_count_reg <= 16'h0000;
      end else if (state_reg != ERR) begin
         if (accept)
            acc_count_reg <= acc_count_reg + 16'd1;
         if (stall)
            stall_count_reg <= stall_count_reg + 16'd1;
      end
   end

   assign acc_count   = acc_count_reg;
   assign stall_count = stall_count_reg;
`else
   // accept is only consumed by the statistics counters
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage access controller on the consumer side of the EX/MEM pipeline register.
- Takes the EXMEM_* access fields, runs the handshake with the multi-cycle data memory, and returns read data toward MEM/WB.
- Generates the `stall` that freezes the EX/MEM register (its enable is ~stall) until the access completes.
- Detects misaligned accesses and memory timeouts; both are reported as a sticky error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY before a timeout error is declared (1..255; the wait counter is 8 bits).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- EXMEM_memRead  input  1  load request
- EXMEM_memWrite  input  1  store request
- EXMEM_noOp  input  1  slot is a bubble; suppresses any access
- EXMEM_memAddr  input  16  byte address
- EXMEM_writeData  input  16  store data
- mem_Stall  input  1  memory cannot accept a new request this cycle
- mem_Done  input  1  access complete; mem_DataOut is valid this cycle for reads
- mem_DataOut  input  16  memory read data
- mem_Rd  output  1  read request to memory
- mem_Wr  output  1  write request to memory
- mem_Addr  output  16  address to memory
- mem_DataIn  output  16  write data to memory
- readData  output  16  load result toward MEM/WB
- stall  output  1  freeze EX/MEM register and upstream stages
- err  output  1  sticky error flag

Behaviour:
- req = (EXMEM_memRead | EXMEM_memWrite) & ~EXMEM_noOp.
- misalign = req & EXMEM_memAddr[0].
- If memRead and memWrite are both high, the access is treated as a read.
- States: IDLE, BUSY, ERR. Reset puts the block in IDLE.
- Reset values: readData holding register 0x0000, wait counter 0, err 0.
- After reset, mem_Rd, mem_Wr and stall are 0 until req is seen.
- mem_Addr = EXMEM_memAddr and mem_DataIn = EXMEM_writeData at all times (combinational).
- IDLE:
  - mem_Rd = req & read & ~misalign; mem_Wr = req & write & ~misalign.
  - Request is accepted on a cycle with (mem_Rd | mem_Wr) & ~mem_Stall.
  - Accepted and mem_Done in the same cycle (hit): stay in IDLE, stall = 0, zero extra latency.
  - Accepted without mem_Done: go to BUSY, stall = 1, wait counter cleared to 0.
  - Not accepted because mem_Stall = 1: stay in IDLE, stall = 1, request held asserted.
  - misalign: go to ERR next cycle, no memory request issued, stall = 1 this cycle.
  - No req: stall = 0.
- BUSY:
  - mem_Rd = mem_Wr = 0; stall = 1 except in the cycle mem_Done = 1.
  - On mem_Done: stall = 0 that cycle, return to IDLE next cycle.
  - Otherwise the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES without mem_Done, go to ERR.
- ERR:
  - Terminal: stall = 1, err = 1, mem_Rd = mem_Wr = 0.
  - Exits only on rst.
- readData:
  - When mem_Done and the completing access is a read: readData = mem_DataOut combinationally, and the holding register captures mem_DataOut at the clock edge.
  - Otherwise readData = holding register.
  - A write completion leaves the holding register unchanged.
- mem_Done arriving in IDLE with no accepted request is ignored: no state change, no capture.
- rst asserted mid-access (BUSY or ERR): next state IDLE; counter, err and holding register cleared. The abandoned memory transaction is not tracked.
- Exactly one request is issued per instruction. Because stall drops in the mem_Done cycle, the EX/MEM register advances on that edge and no re-issue occurs.

Optional Feature:
- Macro MEM_STAGE_STATS_EN.
- When defined, adds output ports:
  - acc_count [15:0]: increments on each accepted request.
  - stall_count [15:0]: increments on each cycle with stall = 1.
- Both counters reset to 0, wrap at 0xFFFF → 0x0000, and freeze while in ERR.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Load hit: memRead = 1, addr = 0x0010, mem_Stall = 0, mem_Done = 1 with mem_DataOut = 0xBEEF in the same cycle → stall = 0 throughout; readData = 0xBEEF that cycle and on following idle cycles.
- Store miss: memWrite = 1, addr = 0x0020, data = 0x1234; mem_Done after 3 cycles → mem_Wr high for 1 cycle; stall = 1 for 3 cycles, 0 in the Done cycle; readData unchanged.
- Memory busy: memRead with mem_Stall = 1 for 2 cycles, then 0 with mem_Done = 1 → mem_Rd held high 3 cycles, stall = 1 for the first 2 cycles.
- Misaligned and noOp: memRead, addr = 0x0011 → no mem_Rd/mem_Wr; err = 1 from the next cycle, stall held 1 until rst. Separately, memWrite with EXMEM_noOp = 1 → no request, stall = 0.
- Timeout: TIMEOUT_CYCLES = 4, read accepted, mem_Done never arrives → ERR entered after 4 BUSY cycles, err = 1. rst then clears err and returns to IDLE; a subsequent read hit completes normally.
- Stats (MEM_STAGE_STATS_EN defined): scenarios 1 and 2 back-to-back → acc_count = 2, stall_count = 3.
